// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared constants, state encoding and helpers for the 3x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] ROW1 = 4'b1000;
    localparam logic [3:0] ROW2 = 4'b0100;
    localparam logic [3:0] ROW3 = 4'b0010;
    localparam logic [3:0] ROW4 = 4'b0001;

    localparam logic [2:0] COL_L = 3'b100;
    localparam logic [2:0] COL_M = 3'b010;
    localparam logic [2:0] COL_R = 3'b001;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == COL_L) || (v == COL_M) || (v == COL_R);
    endfunction

    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : keypad_tick_div
// Brief    : Free-running divider; tick is high on the last cycle of each CLK_DIV period.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_tick_div #(
    parameter int CLK_DIV = 5000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int              W    = $clog2(CLK_DIV);
    localparam logic [W-1:0]    LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 3x4 keypad row scanner with press/release debounce and one-hot key outputs.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int CLK_DIV  = 5000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic [2:0] coluna,
    output logic [3:0] linha,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_strobe
);
    // Named imports keep the DEBOUNCE parameter distinct from the DEBOUNCE state.
    import keypad_pkg::state_e;
    import keypad_pkg::SCAN;
    import keypad_pkg::HELD;
    import keypad_pkg::ROW1;
    import keypad_pkg::ROW2;
    import keypad_pkg::ROW3;
    import keypad_pkg::ROW4;
    import keypad_pkg::COL_L;
    import keypad_pkg::COL_M;
    import keypad_pkg::KEY_STAR;
    import keypad_pkg::KEY_HASH;
    import keypad_pkg::is_onehot3;
    import keypad_pkg::rotate_row;

    localparam int           CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic tick;

    keypad_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    state_e        state_q,   state_d;
    logic [3:0]    row_q,     row_d;
    logic [2:0]    cap_col_q, cap_col_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [CW-1:0] rel_q,     rel_d;
    logic [2:0]    coluna_q,  coluna_d;
    logic [3:0]    linha_q,   linha_d;
    logic          valid_q,   valid_d;
    logic [3:0]    code_q,    code_d;
    logic          strobe_q,  strobe_d;
    logic [CW-1:0] cnt_inc, rel_inc;
    logic          accept;

    function automatic logic [3:0] decode(input logic [3:0] row, input logic [2:0] col);
        logic [3:0] idx;
        logic [3:0] base;
        idx = (col == COL_L) ? 4'd1 : (col == COL_M) ? 4'd2 : 4'd3;
        case (row)
            ROW1:    base = 4'd0;
            ROW2:    base = 4'd3;
            ROW3:    base = 4'd6;
            default: base = 4'd0;
        endcase
        if (row == ROW4) begin
            return (col == COL_L) ? KEY_STAR : (col == COL_M) ? 4'd0 : KEY_HASH;
        end
        return base + idx;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCAN;
            row_q     <= ROW1;
            cap_col_q <= '0;
            cnt_q     <= '0;
            rel_q     <= '0;
            coluna_q  <= '0;
            linha_q   <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cap_col_q <= cap_col_d;
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            coluna_q  <= coluna_d;
            linha_q   <= linha_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cap_col_d = cap_col_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        coluna_d  = coluna_q;
        linha_d   = linha_q;
        valid_d   = valid_q;
        code_d    = code_q;
        strobe_d  = 1'b0;
        accept    = 1'b0;
        cnt_inc   = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
        rel_inc   = (rel_q == DEB_MAX) ? rel_q : rel_q + 1'b1;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (is_onehot3(col_in)) begin
                        cap_col_d = col_in;
                        cnt_d     = ONE;
                        if (DEB_MAX == ONE) begin
                            accept = 1'b1;
                        end else begin
                            state_d = keypad_pkg::DEBOUNCE;
                        end
                    end else begin
                        row_d = rotate_row(row_q);
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (col_in == cap_col_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_MAX) begin
                            accept = 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = rotate_row(row_q);
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    // Any nonzero column, even a different key, just restarts the release count.
                    if (col_in == 3'b000) begin
                        rel_d = rel_inc;
                        if (rel_inc == DEB_MAX) begin
                            rel_d    = '0;
                            cnt_d    = '0;
                            coluna_d = '0;
                            linha_d  = '0;
                            valid_d  = 1'b0;
                            code_d   = '0;
                            row_d    = rotate_row(row_q);
                            state_d  = SCAN;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (accept) begin
            state_d  = HELD;
            rel_d    = '0;
            coluna_d = cap_col_d;
            linha_d  = row_q;
            valid_d  = 1'b1;
            code_d   = decode(row_q, cap_col_d);
            strobe_d = 1'b1;
        end
    end

    assign row_out    = row_q;
    assign coluna     = coluna_q;
    assign linha      = linha_q;
    assign key_valid  = valid_q;
    assign key_code   = code_q;
    assign key_strobe = strobe_q;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 3x4 matrix keypad rows one at a time and samples the column returns.
- Debounces and validates single-key presses.
- Presents the held key as the one-hot coluna/linha pair, plus a numeric key code and a press strobe.
- It is the producing end of the coluna/linha keypad interface that the vending machine controller consumes, replacing direct wiring of the keypad to that controller.

Parameters:
- CLK_DIV, 5000: clock cycles per scan step (row dwell); the sample is taken on the last cycle of the dwell. Minimum 2.
- DEBOUNCE, 8: number of consecutive identical samples needed to accept a press or a release. Minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- col_in  in  3  raw column returns, active-high, already synchronised externally; bit2 = left, bit1 = middle, bit0 = right.
- row_out  out  4  one-hot row drive: 1000 = row 1-2-3, 0100 = row 4-5-6, 0010 = row 7-8-9, 0001 = row *-0-#.
- coluna  out  3  one-hot column of the accepted key; 000 when no key.
- linha  out  4  one-hot row of the accepted key; 0000 when no key.
- key_valid  out  1  high while an accepted key is held.
- key_code  out  4  1-9 = digits, 0 = key 0, 10 = *, 11 = #; 0 when key_valid = 0.
- key_strobe  out  1  one-cycle pulse on acceptance of a press.

Behaviour:
- Reset values: row_out = 1000, coluna = 000, linha = 0000, key_valid = 0, key_code = 0, key_strobe = 0. Divider and debounce counters = 0. State = SCAN.
- Tick: the divider counts 0 to CLK_DIV-1; tick = (count == CLK_DIV-1). All sampling and all state decisions happen only on tick cycles.
- SCAN:
  - On tick, sample col_in against the current row.
  - If col_in is exactly one-hot: capture {row, col}, set cnt = 1, keep row_out frozen. Go to DEBOUNCE, or straight to HELD if DEBOUNCE = 1.
  - Otherwise (000, or more than one bit set): rotate row_out 1000, 0100, 0010, 0001, 1000, and stay in SCAN.
- DEBOUNCE:
  - On tick, if col_in equals the captured column: cnt++. When cnt reaches DEBOUNCE, go to HELD.
  - On tick with any other value: cnt = 0, rotate to the next row, return to SCAN. No outputs change.
- Entering HELD (registered outputs, visible the cycle after the accepting tick):
  - linha = captured row, coluna = captured column, key_valid = 1, key_code = decoded value.
  - key_strobe is high for exactly that one cycle.
- HELD:
  - row_out stays frozen.
  - On tick, col_in == 000 increments the release counter; any nonzero value clears it.
  - A different column while held is ignored: no rollover, no second strobe.
- Release: when the release counter reaches DEBOUNCE, clear coluna, linha, key_valid and key_code on the following cycle, rotate to the next row, and return to SCAN.
- Decode: row 1000 adds 0, 0100 adds 3, 0010 adds 6. Column 100 = 1, 010 = 2, 001 = 3. Row 0001: 100 gives 10 (*), 010 gives 0, 001 gives 11 (#).
- Outputs are only ever all-zero or a legal one-hot pair; no partial updates.
- Reset asserted in any state (including mid-DEBOUNCE or HELD) forces the reset values at the next rising edge; no strobe is emitted.
- Reset has priority over tick.
- Counter widths: divider uses clog2(CLK_DIV) bits; debounce counters use clog2(DEBOUNCE+1) bits. They saturate and never wrap.

Decomposition:
- Shared package keypad_pkg holds:
  - row one-hot constants ROW1..ROW4;
  - column constants COL_L, COL_M, COL_R;
  - key-code constants KEY_STAR = 10, KEY_HASH = 11;
  - state encoding SCAN, DEBOUNCE, HELD.
- One natural sub-module: keypad_tick_div (parameter CLK_DIV; ports clock, reset, tick), instantiated once.
- Decode stays inline as a small function.

Test Plan (CLK_DIV = 4, DEBOUNCE = 3):
- Reset, col_in = 000 for 40 cycles: row_out sequence is 1000, 0100, 0010, 0001, 1000, changing every 4 cycles. coluna, linha, key_valid and key_strobe stay 0.
- Key 5 (col_in = 010 whenever row_out = 0100), held: detected on the 0100 sample. Exactly one key_strobe pulse 8 cycles later (+1 registered), with linha = 0100, coluna = 010, key_code = 5, key_valid = 1, and row_out frozen at 0100.
- Bounce on # (col_in = 001 on row 0001 for 2 samples, then 000): no strobe, key_valid stays 0, scanning resumes at 1000.
- Two keys (col_in = 110 on row 1000): ignored, rotation continues, no strobe. Same result for col_in = 111.
- Release of held key 0 (col 010, row 0001): col_in = 000 for 3 ticks, then key_valid = 0, key_code = 0, coluna = 000, linha = 0000, and row_out moves to 1000. A single 010 glitch after 2 zero ticks restarts the release count.
- Reset pulse while in HELD for key 9: the next edge gives row_out = 1000 and all other outputs 0, with no strobe.
